// File: rtl/sram_alloc_matcher_if.sv
// Request / scan / result bundle for sram_alloc_matcher.
// slave = the matcher, master = whoever issues requests and presents SRAM status.
interface sram_alloc_matcher_if #(
  parameter int SRAM_NUM = 32,
  parameter int PORT_NUM = 16,
  parameter int LEN_W    = 9,
  parameter int SPACE_W  = 11,
  parameter int AMOUNT_W = 9,
  parameter int TICK_W   = 8
);
  localparam int SRAM_W = $clog2(SRAM_NUM);
  localparam int PORT_W = $clog2(PORT_NUM);

  logic [TICK_W-1:0]   match_threshold;
  logic [TICK_W-1:0]   match_timeout;
  logic                req_valid;
  logic                req_ready;
  logic [PORT_W-1:0]   req_dest_port;
  logic [LEN_W-1:0]    req_length;
  logic                viscous;
  logic                sticky_flush;
  logic [SRAM_W-1:0]   scan_sram;
  logic                scan_accessible;
  logic [SPACE_W-1:0]  scan_free_space;
  logic [AMOUNT_W-1:0] scan_packet_amount;
  logic                update_best;
  logic [SRAM_W-1:0]   best_sram;
  logic                match_valid;
  logic [SRAM_W-1:0]   match_sram;
  logic                match_sticky;
  logic                match_fail;
  logic [1:0]          state;

  modport slave (
    input  match_threshold, match_timeout, req_valid, req_dest_port, req_length,
           viscous, sticky_flush, scan_sram, scan_accessible, scan_free_space,
           scan_packet_amount,
    output req_ready, update_best, best_sram, match_valid, match_sram,
           match_sticky, match_fail, state
  );

  modport master (
    output match_threshold, match_timeout, req_valid, req_dest_port, req_length,
           viscous, sticky_flush, scan_sram, scan_accessible, scan_free_space,
           scan_packet_amount,
    input  req_ready, update_best, best_sram, match_valid, match_sram,
           match_sticky, match_fail, state
  );
endinterface

// File: rtl/sram_alloc_matcher.sv
// Write-side SRAM allocator: picks the accessible SRAM with enough room that
// already holds the most packets for the destination (ties -> more free space).
// Optional sticky reuse of the last SRAM is enabled by defining MATCHER_STICKY_EN.
module sram_alloc_matcher #(
  parameter int SRAM_NUM = 32,
  parameter int PORT_NUM = 16,
  parameter int LEN_W    = 9,
  parameter int SPACE_W  = 11,
  parameter int AMOUNT_W = 9,
  parameter int TICK_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  sram_alloc_matcher_if.slave bus
);
  localparam int SRAM_W = $clog2(SRAM_NUM);
  localparam int PORT_W = $clog2(PORT_NUM);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2, S_FAIL = 2'd3} state_t;

  state_t              r_state, w_state_nxt;
  logic [PORT_W-1:0]   r_dest;
  logic [LEN_W-1:0]    r_len;
  logic [TICK_W-1:0]   r_tick;
  logic                r_find;
  logic [SRAM_W-1:0]   r_best_sram;
  logic [AMOUNT_W-1:0] r_best_amount;
  logic [SPACE_W-1:0]  r_best_free;

  logic                w_accept, w_hit, w_qual, w_better, w_exit_done, w_exit_fail, w_update;
  logic [SPACE_W-1:0]  w_len_ext;
  logic [SRAM_W-1:0]   w_done_sram;

  assign w_accept    = bus.req_valid && (r_state == S_IDLE);
  assign w_len_ext   = SPACE_W'(r_len);
  assign w_qual      = bus.scan_accessible && (bus.scan_free_space >= w_len_ext);
  assign w_better    = !r_find || (bus.scan_packet_amount > r_best_amount) ||
                       ((bus.scan_packet_amount == r_best_amount) && (bus.scan_free_space > r_best_free));
  // exit decisions look only at registered find/tick, so the exit cycle never compares
  assign w_exit_done = r_find && (r_tick >= bus.match_threshold);
  assign w_exit_fail = !r_find && (bus.match_timeout != '0) && (r_tick >= bus.match_timeout);
  assign w_update    = (r_state == S_SCAN) && !w_exit_done && !w_exit_fail && w_qual && w_better;

`ifdef MATCHER_STICKY_EN
  logic [PORT_W-1:0]  r_last_dest;
  logic [SRAM_W-1:0]  r_last_sram;
  logic [SPACE_W-1:0] r_last_free;
  logic               r_sticky_valid;
  logic               r_hit_sticky;

  assign w_hit = r_sticky_valid && bus.viscous && (bus.req_dest_port == r_last_dest) &&
                 (r_last_free >= SPACE_W'(bus.req_length));
  assign w_done_sram  = r_hit_sticky ? r_last_sram : r_best_sram;
  assign bus.match_sticky = (r_state == S_DONE) && r_hit_sticky;

  // sticky bookkeeping; flush is last so it beats the DONE reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dest    <= '0;
      r_last_sram    <= '0;
      r_last_free    <= '0;
      r_sticky_valid <= 1'b0;
      r_hit_sticky   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hit_sticky <= w_hit;
        if (w_hit) r_last_free <= r_last_free - SPACE_W'(bus.req_length);
      end
      if (r_state == S_DONE && !r_hit_sticky) begin
        r_last_dest    <= r_dest;
        r_last_sram    <= r_best_sram;
        r_last_free    <= r_best_free - w_len_ext;
        r_sticky_valid <= 1'b1;
      end
      if (r_state == S_FAIL) r_sticky_valid <= 1'b0;
      if (bus.sticky_flush)  r_sticky_valid <= 1'b0;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok      = ^{bus.viscous, bus.sticky_flush, r_dest};
  assign w_hit            = 1'b0;
  assign w_done_sram      = r_best_sram;
  assign bus.match_sticky = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_hit ? S_DONE : S_SCAN;
      S_SCAN: begin
        if (w_exit_done)      w_state_nxt = S_DONE;
        else if (w_exit_fail) w_state_nxt = S_FAIL;
      end
      S_DONE: w_state_nxt = S_IDLE;
      S_FAIL: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // request capture and best-candidate tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest        <= '0;
      r_len         <= '0;
      r_tick        <= '0;
      r_find        <= 1'b0;
      r_best_sram   <= '0;
      r_best_amount <= '0;
      r_best_free   <= '0;
    end else begin
      if (w_accept) begin
        r_dest <= bus.req_dest_port;
        r_len  <= bus.req_length;
        if (!w_hit) begin
          r_tick        <= '0;
          r_find        <= 1'b0;
          r_best_amount <= '0;
        end
      end
      if (r_state == S_SCAN) begin
        if (r_tick != '1) r_tick <= r_tick + 1'b1;
        if (w_update) begin
          r_find        <= 1'b1;
          r_best_sram   <= bus.scan_sram;
          r_best_amount <= bus.scan_packet_amount;
          r_best_free   <= bus.scan_free_space;
        end
      end
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.update_best = w_update;
  assign bus.best_sram   = r_best_sram;
  assign bus.match_valid = (r_state == S_DONE);
  assign bus.match_sram  = (r_state == S_DONE) ? w_done_sram : '0;
  assign bus.match_fail  = (r_state == S_FAIL);
  assign bus.state       = r_state;
endmodule
